// File: rtl/wb_host_master.sv
// Wishbone classic initiator: turns one command into one bus cycle and returns one response.
// A bus cycle ends with rsp_err set if it waits TIMEOUT_CYCLES cycles without an ack.
module wb_host_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] count;
    logic       timeout_hit;

    assign timeout_hit = (count == TIMEOUT_LAST);

    // Strobe and handshakes are decoded from the state alone, so reset drops cyc/stb at once.
    assign cmd_ready = (state == IDLE);
    assign wbm_cyc_o = (state == BUS);
    assign wbm_stb_o = (state == BUS);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = BUS;
            BUS:     if (wbm_ack_i || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            count     <= 8'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= cmd_addr;
                        wbm_dat_o <= cmd_wdata;
                        count     <= 8'h0;
                    end
                end
                BUS: begin
                    // An ack arriving on the timeout cycle still completes the transfer cleanly.
                    if (wbm_ack_i) begin
                        if (!wbm_we_o) begin
                            rsp_rdata <= wbm_dat_i;
                        end
                        rsp_err <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_err <= 1'b1;
                    end else begin
                        count <= count + 8'h1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master with a configurable-delay Wishbone responder
// and a response scoreboard filled when commands are issued.
module tb_wb_host_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;

    logic        resp_enable;
    int          ack_after;
    int          stb_cnt;
    logic        ack_r;
    logic        stray_ack;
    logic [31:0] resp_data;

    logic        exp_we;
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;
    logic [3:0]  exp_sel;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_host_master #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i)
    );

    // Responder: acks on the ack_after-th strobe cycle, one-cycle ack pulse, never a second strobe.
    always @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_r   <= 1'b0;
            stb_cnt <= 0;
        end else if (wbm_cyc_o && wbm_stb_o && !ack_r) begin
            stb_cnt <= stb_cnt + 1;
            ack_r   <= resp_enable && (stb_cnt + 1 == ack_after);
        end else begin
            ack_r   <= 1'b0;
            stb_cnt <= 0;
        end
    end

    assign wbm_ack_i = ack_r | stray_ack;
    assign wbm_dat_i = resp_data;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                                 input logic [3:0] sel, input logic [31:0] exp_rdata, input logic exp_err);
        rsp_t e;
        cmd_we    = we;
        cmd_addr  = adr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        exp_we    = we;
        exp_adr   = adr;
        exp_dat   = wdata;
        exp_sel   = sel;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        sb_q.push_back(e);
    endtask

    // Call at the negedge before the accepting edge; returns at the negedge where rsp_valid is seen.
    task automatic waitResponse(input string tag, input int exp_bus, input int exp_lat);
        int   lat = 0;
        int   bus = 0;
        int   pulses = 0;
        logic prev_cyc = 1'b0;
        logic got = 1'b0;
        logic bad_attr = 1'b0;
        rsp_t e;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge wb_clk_i);
            cmd_valid = 1'b0;
            lat++;
            if (wbm_cyc_o && wbm_stb_o) begin
                bus++;
                if (!prev_cyc) pulses++;
                if ({wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {exp_we, exp_adr, exp_dat, exp_sel})
                    bad_attr = 1'b1;
            end
            prev_cyc = wbm_cyc_o;
            if (rsp_valid) got = 1'b1;
        end
        checkOutput({tag, "_rsp_seen"}, 64'(got), 64'd1);
        checkOutput({tag, "_bus_cycles"}, 64'(bus), 64'(exp_bus));
        checkOutput({tag, "_stb_pulses"}, 64'(pulses), 64'd1);
        checkOutput({tag, "_latency"}, 64'(lat - 1), 64'(exp_lat));
        checkOutput({tag, "_bus_attrs"}, 64'(bad_attr), 64'd0);
        checkOutput({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
        if (got && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            checkOutput({tag, "_err"}, 64'(rsp_err), 64'(e.err));
        end
        if (rsp_ready) begin
            @(negedge wb_clk_i);
            checkOutput({tag, "_back_idle"}, 64'({rsp_valid, cmd_ready, wbm_cyc_o}), 64'b010);
        end
    endtask

    initial begin
        logic hold_ctrl_bad;
        logic hold_data_bad;
        int   seen;
        wb_rst_n_i  = 1'b0;
        cmd_valid   = 1'b0;
        cmd_we      = 1'b0;
        cmd_addr    = 32'h0;
        cmd_wdata   = 32'h0;
        cmd_sel     = 4'h0;
        rsp_ready   = 1'b1;
        resp_enable = 1'b1;
        ack_after   = 1;
        stray_ack   = 1'b0;
        resp_data   = 32'h0;
        exp_we      = 1'b0;
        exp_adr     = 32'h0;
        exp_dat     = 32'h0;
        exp_sel     = 4'h0;

        repeat (3) @(negedge wb_clk_i);
        checkOutput("reset_ctrl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid, rsp_err, cmd_ready}),
                    64'b0000000001);
        checkOutput("reset_adr", 64'(wbm_adr_o), 64'h0);
        checkOutput("reset_dat", 64'(wbm_dat_o), 64'h0);
        checkOutput("reset_rdata", 64'(rsp_rdata), 64'h0);

        // Command presented with reset release is taken on the very next edge.
        wb_rst_n_i = 1'b1;
        resp_data  = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 32'h3030_0000, 32'h0000_000A, 4'hF, 32'h0, 1'b0);
        waitResponse("write", 2, 2);

        resp_data = 32'h0000_0003;
        applyStimulus(1'b0, 32'h3020_0000, 32'h0, 4'hF, 32'h0000_0003, 1'b0);
        waitResponse("read", 2, 2);

        resp_data = 32'h7777_7777;
        stray_ack = 1'b1;
        @(negedge wb_clk_i);
        stray_ack = 1'b0;
        checkOutput("idle_stray_ack_ctrl", 64'({cmd_ready, wbm_cyc_o, rsp_valid}), 64'b100);
        checkOutput("idle_stray_ack_rdata", 64'(rsp_rdata), 64'h0000_0003);

        resp_enable = 1'b0;
        resp_data   = 32'h5555_5555;
        applyStimulus(1'b0, 32'h3040_0000, 32'h0, 4'hF, 32'h0000_0003, 1'b1);
        waitResponse("timeout", 4, 4);
        resp_enable = 1'b1;

        ack_after = 3;
        resp_data = 32'h1234_5678;
        applyStimulus(1'b0, 32'h3040_0004, 32'h0, 4'h3, 32'h1234_5678, 1'b0);
        waitResponse("ack_vs_timeout", 4, 4);
        ack_after = 1;

        rsp_ready = 1'b0;
        resp_data = 32'hCAFE_F00D;
        applyStimulus(1'b0, 32'h3050_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);
        waitResponse("backpressure", 2, 2);

        // Hold the response while a new command and a stray ack try to disturb it.
        applyStimulus(1'b1, 32'h3060_0000, 32'h0000_00BB, 4'h1, 32'hCAFE_F00D, 1'b0);
        hold_ctrl_bad = 1'b0;
        hold_data_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stray_ack = (i == 4);
            resp_data = $urandom;
            @(negedge wb_clk_i);
            if ({rsp_valid, cmd_ready, wbm_cyc_o, wbm_stb_o} !== 4'b1000) hold_ctrl_bad = 1'b1;
            if ({rsp_rdata, rsp_err, wbm_adr_o, wbm_we_o} !== {32'hCAFE_F00D, 1'b0, 32'h3050_0000, 1'b0})
                hold_data_bad = 1'b1;
        end
        stray_ack = 1'b0;
        checkOutput("hold_ctrl", 64'(hold_ctrl_bad), 64'd0);
        checkOutput("hold_data", 64'(hold_data_bad), 64'd0);

        rsp_ready = 1'b1;
        resp_data = 32'h0F0F_0F0F;
        @(negedge wb_clk_i);
        checkOutput("release_idle", 64'({rsp_valid, cmd_ready, wbm_cyc_o}), 64'b010);
        waitResponse("post_backpressure", 2, 2);

        resp_enable = 1'b0;
        applyStimulus(1'b0, 32'h3070_0000, 32'h0, 4'hF, 32'h0, 1'b0);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        checkOutput("midreset_in_bus", 64'({wbm_cyc_o, wbm_stb_o}), 64'b11);
        @(negedge wb_clk_i);
        #2 wb_rst_n_i = 1'b0;
        #1;
        checkOutput("midreset_ctrl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid, rsp_err, cmd_ready}),
                    64'b0000000001);
        checkOutput("midreset_adr", 64'(wbm_adr_o), 64'h0);
        checkOutput("midreset_rdata", 64'(rsp_rdata), 64'h0);
        sb_q.delete();
        repeat (2) @(negedge wb_clk_i);
        wb_rst_n_i  = 1'b1;
        resp_enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk_i);
            if (rsp_valid || wbm_cyc_o) seen++;
        end
        checkOutput("post_reset_quiet", 64'(seen), 64'd0);

        resp_data = 32'h0BAD_F00D;
        applyStimulus(1'b0, 32'h3080_0000, 32'h0, 4'hC, 32'h0BAD_F00D, 1'b0);
        waitResponse("after_reset_read", 2, 2);

        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles a bus cycle waits for ack; legal range 1..255.
REQ-002 The block SHALL have port wb_clk_i, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-003 The block SHALL have port wb_rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_we (input, 1), cmd_addr (input, 32), cmd_wdata (input, 32) and cmd_sel (input, 4), forming the command request channel.
REQ-005 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, 32) and rsp_err (output, 1, timeout flag), forming the response channel.
REQ-006 The block SHALL have Wishbone initiator ports wbm_cyc_o (1), wbm_stb_o (1), wbm_we_o (1), wbm_sel_o (4), wbm_adr_o (32) and wbm_dat_o (32) as outputs, and wbm_dat_i (32) and wbm_ack_i (1) as inputs.

Function
REQ-007 The block SHALL implement a three-state FSM with states IDLE, BUS and RESP.
REQ-008 cmd_ready SHALL be 1 exactly when the state is IDLE; it SHALL be combinational from the state only and never from cmd_valid.
REQ-009 In IDLE, when cmd_valid=1, the block SHALL register cmd_we, cmd_addr, cmd_wdata and cmd_sel, load the timeout counter with 0 and enter BUS on the next edge.
REQ-010 In BUS, wbm_cyc_o and wbm_stb_o SHALL be 1, and wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o SHALL hold the registered command values, stable for the whole cycle.
REQ-011 Outside BUS, wbm_cyc_o and wbm_stb_o SHALL be 0; wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o SHALL keep their last values.
REQ-012 In BUS, when wbm_ack_i=1, the block SHALL capture wbm_dat_i into rsp_rdata for reads, clear rsp_err and enter RESP.
REQ-013 Write responses SHALL leave rsp_rdata unchanged.
REQ-014 In BUS without ack, the 8-bit timeout counter SHALL increment each cycle.
REQ-015 When the timeout counter equals TIMEOUT_CYCLES-1 and wbm_ack_i=0, the block SHALL set rsp_err=1, leave rsp_rdata unchanged and enter RESP.
REQ-016 If ack and timeout coincide in the same cycle, ack SHALL win and rsp_err SHALL be 0.
REQ-017 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be stable until rsp_ready=1.
REQ-018 On the edge where rsp_ready=1 in RESP, the block SHALL return to IDLE.
REQ-019 A new command SHALL be accepted no earlier than the following cycle; there is no command/response overlap.
REQ-020 wbm_ack_i asserted while not in BUS SHALL be ignored: no state change and no data capture.
REQ-021 Latency SHALL be as follows: command accepted at edge N; cyc/stb high from N+1; ack sampled at edge N+1+k, where k≥1 is the responder delay; rsp_valid high from that edge.
REQ-022 Against a responder that registers ack one cycle after seeing stb, the round-trip from cmd accept to rsp_valid SHALL be exactly 2 cycles.
REQ-023 Deassertion of cyc/stb SHALL occur on the same edge that samples ack, so a responder guarding ack with its own registered ack never sees a second strobe.

Reset
REQ-024 While wb_rst_n_i=0, regardless of clock, the block SHALL force state=IDLE, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and counter=0.
REQ-025 Reset asserted mid-BUS SHALL drop cyc/stb immediately (asynchronously) and discard the transaction; no response is produced.
REQ-026 Reset deassertion SHALL be treated as synchronous to wb_clk_i by the integrator, and the first command SHALL be accepted on the first edge after release.

Verification
REQ-027 Write scenario: cmd write adr=0x3030_0000, dat=0x0000_000A, sel=0xF; responder acks 1 cycle after stb -> exactly one cyc/stb pulse of 2 cycles, rsp_valid 2 cycles after accept, rsp_err=0.
REQ-028 Read scenario: cmd read adr=0x3020_0000; responder returns 0x0000_0003 with ack -> rsp_rdata=0x0000_0003, rsp_err=0, wbm_we_o=0 throughout.
REQ-029 Timeout scenario: TIMEOUT_CYCLES=4, read to 0x3040_0000, responder never acks -> cyc/stb high exactly 4 cycles, rsp_err=1, rsp_rdata keeps the previous value.
REQ-030 Ack/timeout coincidence scenario: TIMEOUT_CYCLES=4, ack on the 4th BUS cycle -> rsp_err=0 and data captured.
REQ-031 Backpressure scenario: rsp_ready held 0 for 10 cycles, with cmd_valid held 1 and a stray ack pulse injected -> rsp_valid and data stable, cmd_ready=0, no new bus cycle; release rsp_ready -> IDLE, next command accepted one cycle later.
REQ-032 Reset mid-operation scenario: wb_rst_n_i pulsed low during BUS -> cyc/stb low without a clock edge, all outputs at reset values, and no rsp_valid after release.
